// File: rtl/friscv_h.sv
// Shared definitions for the friscv RV32I control unit: opcodes, branch
// funct3 codes, ALU instruction bus width and FIFO depth.
package friscv_h;

  localparam int ALU_INSTBUS_W  = 32;
  localparam int ALU_FIFO_DEPTH = 4;

  typedef enum logic [6:0] {
    OPC_NOP    = 7'b0000000,
    OPC_LOAD   = 7'b0000011,
    OPC_OPIMM  = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111,
    OPC_SYSTEM = 7'b1110011
  } opcode_e;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } branch_f3_e;

  // Instructions resolved locally: they change the pc non-sequentially or
  // read the pc, so they must wait until older ALU work has drained.
  function automatic logic is_ctrl_flow(logic [6:0] opc);
    return opc inside {OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH};
  endfunction

  // Instructions handed to the ALU through the instruction FIFO.
  function automatic logic is_alu_op(logic [6:0] opc);
    return opc inside {OPC_LOAD, OPC_LUI, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_SYSTEM};
  endfunction

  function automatic logic is_valid_opcode(logic [6:0] opc);
    return is_ctrl_flow(opc) | is_alu_op(opc) | (opc == OPC_NOP);
  endfunction

endpackage

// File: rtl/friscv_rv32i_control_unit_if.sv
// Bus bundle of the control unit: instruction fetch, ALU instruction
// hand-off and register-file access. master = control unit side.
interface friscv_rv32i_control_unit_if #(
  parameter int ADDRW = 16,
  parameter int XLEN  = 32
);
  import friscv_h::*;

  logic                     inst_en;
  logic [ADDRW-1:0]         inst_addr;
  logic [XLEN-1:0]          inst_rdata;
  logic                     inst_ready;

  logic                     alu_en;
  logic                     alu_ready;
  logic [ALU_INSTBUS_W-1:0] alu_instbus;

  logic [4:0]               ctrl_rs1_addr;
  logic [XLEN-1:0]          ctrl_rs1_val;
  logic [4:0]               ctrl_rs2_addr;
  logic [XLEN-1:0]          ctrl_rs2_val;
  logic                     ctrl_rd_wr;
  logic [4:0]               ctrl_rd_addr;
  logic [XLEN-1:0]          ctrl_rd_val;

  modport master (
    output inst_en, inst_addr,
    input  inst_rdata, inst_ready,
    output alu_en, alu_instbus,
    input  alu_ready,
    output ctrl_rs1_addr, ctrl_rs2_addr,
    input  ctrl_rs1_val, ctrl_rs2_val,
    output ctrl_rd_wr, ctrl_rd_addr, ctrl_rd_val
  );

  modport slave (
    input  inst_en, inst_addr,
    output inst_rdata, inst_ready,
    input  alu_en, alu_instbus,
    output alu_ready,
    input  ctrl_rs1_addr, ctrl_rs2_addr,
    output ctrl_rs1_val, ctrl_rs2_val,
    input  ctrl_rd_wr, ctrl_rd_addr, ctrl_rd_val
  );

endinterface

// File: rtl/friscv_scfifo.sv
// Single-clock first-word-fall-through FIFO. The head word is always visible
// on data_out while not empty; a push is accepted when full if a pop happens
// in the same cycle, and a pop on an empty FIFO is ignored.
module friscv_scfifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push, do_pop;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == (AW+1)'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign data_out = mem[rd_ptr_reg];

  // Storage write; contents need no reset since the flags gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= data_in;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= (wr_ptr_reg == AW'(DEPTH-1)) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= (rd_ptr_reg == AW'(DEPTH-1)) ? '0 : rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/friscv_rv32i_control_unit.sv
// RV32I control/fetch unit: owns the pc, fetches instructions, resolves
// AUIPC/JAL/JALR/branches locally and queues the rest for the ALU.
module friscv_rv32i_control_unit
  import friscv_h::*;
#(
  parameter int              ADDRW     = 16,
  parameter logic [31:0]     BOOT_ADDR = 32'h0,
  parameter int              XLEN      = 32
) (
  input  logic                          aclk,
  input  logic                          srst,
  friscv_rv32i_control_unit_if.master   bus
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] rs1_val, rs2_val;

  logic            inst_error;
  logic            ctrl_flow_op;
  logic            alu_op;
  logic            accept;
  logic            alu_inst_wr;
  logic            fifo_full, fifo_empty;
  logic            branch_taken;

  logic [XLEN-1:0] imm_u, imm_j, imm_i, imm_b;
  logic [XLEN-1:0] pc_plus4, jalr_sum;

  logic [XLEN-1:0] pc_reg, pc_next;
  logic            rd_wr_reg, rd_wr_next;
  logic [4:0]      rd_addr_reg, rd_addr_next;
  logic [XLEN-1:0] rd_val_reg, rd_val_next;

  assign inst    = bus.inst_rdata;
  assign opcode  = inst[6:0];
  assign funct3  = inst[14:12];
  assign rs1_val = bus.ctrl_rs1_val;
  assign rs2_val = bus.ctrl_rs2_val;

  assign bus.ctrl_rs1_addr = inst[19:15];
  assign bus.ctrl_rs2_addr = inst[24:20];

  // Decode is purely combinational on the presented word, whether or not
  // it is valid yet.
  assign inst_error   = ~is_valid_opcode(opcode);
  assign ctrl_flow_op = is_ctrl_flow(opcode);
  assign alu_op       = is_alu_op(opcode) & ~inst_error;

  // Control-flow instructions hold off until the ALU has consumed every
  // older instruction, so rd writes and pc changes stay in program order.
  assign bus.inst_en = ~srst & ~fifo_full & ~(ctrl_flow_op & ~fifo_empty);
  assign accept      = bus.inst_en & bus.inst_ready;
  assign alu_inst_wr = accept & alu_op;

  assign imm_u    = {inst[31:12], 12'h000};
  assign imm_j    = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_i    = {{20{inst[31]}}, inst[31:20]};
  assign imm_b    = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign pc_plus4 = pc_reg + XLEN'(4);
  assign jalr_sum = rs1_val + imm_i;

  // Branch condition evaluation from funct3; undefined encodings never branch.
  always_comb begin
    branch_taken = 1'b0;
    case (funct3)
      BEQ:     branch_taken = (rs1_val == rs2_val);
      BNE:     branch_taken = (rs1_val != rs2_val);
      BLT:     branch_taken = ($signed(rs1_val) <  $signed(rs2_val));
      BGE:     branch_taken = ($signed(rs1_val) >= $signed(rs2_val));
      BLTU:    branch_taken = (rs1_val <  rs2_val);
      BGEU:    branch_taken = (rs1_val >= rs2_val);
      default: branch_taken = 1'b0;
    endcase
  end

  // Next pc and rd write-back for the instruction accepted this cycle.
  always_comb begin
    pc_next      = pc_reg;
    rd_wr_next   = 1'b0;
    rd_addr_next = rd_addr_reg;
    rd_val_next  = rd_val_reg;
    if (accept) begin
      pc_next = pc_plus4;
      case (opcode)
        OPC_AUIPC: begin
          pc_next      = pc_reg + imm_u;
          rd_wr_next   = 1'b1;
          rd_addr_next = inst[11:7];
          rd_val_next  = pc_reg + imm_u;
        end
        OPC_JAL: begin
          pc_next      = pc_reg + imm_j;
          rd_wr_next   = 1'b1;
          rd_addr_next = inst[11:7];
          rd_val_next  = pc_plus4;
        end
        OPC_JALR: begin
          pc_next      = {jalr_sum[XLEN-1:1], 1'b0};
          rd_wr_next   = 1'b1;
          rd_addr_next = inst[11:7];
          rd_val_next  = pc_plus4;
        end
        OPC_BRANCH: begin
          if (branch_taken) begin
            pc_next = pc_reg + imm_b;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Program counter and registered rd write port.
  always_ff @(posedge aclk) begin
    if (srst) begin
      pc_reg      <= BOOT_ADDR;
      rd_wr_reg   <= 1'b0;
      rd_addr_reg <= '0;
      rd_val_reg  <= '0;
    end else begin
      pc_reg      <= pc_next;
      rd_wr_reg   <= rd_wr_next;
      rd_addr_reg <= rd_addr_next;
      rd_val_reg  <= rd_val_next;
    end
  end

  assign bus.inst_addr    = pc_reg[ADDRW-1:0];
  assign bus.ctrl_rd_wr   = rd_wr_reg;
  assign bus.ctrl_rd_addr = rd_addr_reg;
  assign bus.ctrl_rd_val  = rd_val_reg;

  friscv_scfifo #(
    .WIDTH (ALU_INSTBUS_W),
    .DEPTH (ALU_FIFO_DEPTH)
  ) u_alu_fifo (
    .clk      (aclk),
    .srst     (srst),
    .push     (alu_inst_wr),
    .data_in  (inst),
    .pop      (bus.alu_ready),
    .data_out (bus.alu_instbus),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign bus.alu_en = ~fifo_empty;

endmodule

// File: tb/tb_friscv_rv32i_control_unit.sv
// Randomised scoreboard bench for friscv_rv32i_control_unit with directed
// opcode, ALU back-pressure, AUIPC/JAL/JALR and branch sequences.
module tb_friscv_rv32i_control_unit;
  import friscv_h::*;

  logic aclk = 1'b0;
  logic srst = 1'b1;
  always #5 aclk = ~aclk;

  friscv_rv32i_control_unit_if #(.ADDRW(16), .XLEN(32)) bus();

  friscv_rv32i_control_unit #(
    .ADDRW(16), .BOOT_ADDR(32'h0), .XLEN(32)
  ) dut (
    .aclk (aclk),
    .srst (srst),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;
  int ready_mode = 0;  // 0: alu_ready low, 1: high, 2: random

  typedef struct packed { logic [4:0] addr; logic [31:0] val; } rd_t;
  typedef struct packed { logic [31:0] npc; logic wr; logic [4:0] rd; logic [31:0] val; logic alu; } step_t;

  logic [31:0] alu_q[$];
  rd_t         rd_q[$];
  logic [31:0] model_pc;

  logic [6:0] valid_opc [11] = '{7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                                 7'b0000011, 7'b0110111, 7'b0100011, 7'b0010011,
                                 7'b0110011, 7'b1110011, 7'b0000000};
  logic [6:0] bad_opc [3] = '{7'b0000001, 7'b0101001, 7'b1111111};
  logic [6:0] alu_opc [6] = '{7'b0000011, 7'b0110111, 7'b0100011, 7'b0010011,
                              7'b0110011, 7'b1110011};
  logic [2:0] br_f3 [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic bit is_ctrl(logic [31:0] ins);
    return ins[6:0] == 7'b0010111 || ins[6:0] == 7'b1101111 ||
           ins[6:0] == 7'b1100111 || ins[6:0] == 7'b1100011;
  endfunction

  // Architectural effect of one accepted instruction.
  function automatic step_t ref_step(logic [31:0] pc, logic [31:0] ins,
                                     logic [31:0] a, logic [31:0] b);
    step_t s;
    logic [31:0] imm;
    bit taken;
    s = '0;
    s.npc = pc + 32'd4;
    s.rd  = ins[11:7];
    taken = 1'b0;
    case (ins[6:0])
      7'b0010111: begin
        s.npc = pc + {ins[31:12], 12'h000};
        s.wr = 1'b1; s.val = s.npc;
      end
      7'b1101111: begin
        imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
        s.npc = pc + imm; s.wr = 1'b1; s.val = pc + 32'd4;
      end
      7'b1100111: begin
        imm = {{20{ins[31]}}, ins[31:20]};
        s.npc = (a + imm) & 32'hFFFF_FFFE; s.wr = 1'b1; s.val = pc + 32'd4;
      end
      7'b1100011: begin
        imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
        case (ins[14:12])
          3'b000:  taken = (a == b);
          3'b001:  taken = (a != b);
          3'b100:  taken = ($signed(a) < $signed(b));
          3'b101:  taken = ($signed(a) >= $signed(b));
          3'b110:  taken = (a < b);
          3'b111:  taken = (a >= b);
          default: taken = 1'b0;
        endcase
        if (taken) s.npc = pc + imm;
      end
      7'b0000011, 7'b0110111, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1110011:
        s.alu = 1'b1;
      default: ;
    endcase
    return s;
  endfunction

  // Fetch is allowed unless the queue of pending ALU work is full, or a
  // control-flow instruction is waiting behind pending ALU work.
  function automatic bit exp_en(logic [31:0] ins);
    int occ;
    occ = alu_q.size();
    return (occ < ALU_FIFO_DEPTH) && !(is_ctrl(ins) && occ != 0);
  endfunction

  // Present one instruction until accepted; record expected effects.
  task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    step_t s;
    rd_t e;
    bit done;
    done = 1'b0;
    bus.inst_rdata   = ins;
    bus.ctrl_rs1_val = a;
    bus.ctrl_rs2_val = b;
    bus.inst_ready   = 1'b1;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge aclk);
      chk("inst_en", {31'b0, bus.inst_en}, {31'b0, exp_en(ins)});
      if (bus.inst_en === 1'b1) begin
        chk("inst_addr", {16'b0, bus.inst_addr}, {16'b0, model_pc[15:0]});
        s = ref_step(model_pc, ins, a, b);
        if (s.alu) alu_q.push_back(ins);
        if (s.wr) begin
          e.addr = s.rd; e.val = s.val;
          rd_q.push_back(e);
        end
        $display("[TB] accept pc=%h inst=%h rs1=%h rs2=%h next_pc=%h", model_pc, ins, a, b, s.npc);
        model_pc = s.npc;
        done = 1'b1;
      end
      @(posedge aclk); #1;
    end
    bus.inst_ready = 1'b0;
    if (!done) begin
      tests++; fails++;
      $display("FAIL issue_timeout: inst %h never accepted, got inst_en=%b, required 1", ins, bus.inst_en);
    end
  endtask

  task automatic do_reset();
    srst = 1'b1;
    bus.inst_ready = 1'b0;
    @(negedge aclk);
    #2;
    alu_q.delete();
    rd_q.delete();
    @(negedge aclk);
    chk("rst_inst_en", {31'b0, bus.inst_en}, 32'd0);
    chk("rst_rd_wr", {31'b0, bus.ctrl_rd_wr}, 32'd0);
    chk("rst_rd_addr", {27'b0, bus.ctrl_rd_addr}, 32'd0);
    chk("rst_rd_val", bus.ctrl_rd_val, 32'd0);
    chk("rst_alu_en", {31'b0, bus.alu_en}, 32'd0);
    chk("rst_pc", {16'b0, bus.inst_addr}, 32'd0);
    @(posedge aclk); #1;
    srst = 1'b0;
    model_pc = 32'h0;
    @(negedge aclk);
    chk("post_rst_inst_en", {31'b0, bus.inst_en}, 32'd1);
    @(posedge aclk); #1;
  endtask

  // ALU-side back-pressure generator.
  initial begin
    bus.alu_ready = 1'b0;
    forever begin
      @(posedge aclk); #1;
      case (ready_mode)
        0:       bus.alu_ready = 1'b0;
        1:       bus.alu_ready = 1'b1;
        default: bus.alu_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compares ALU pops and rd write pulses against the scoreboard.
  initial begin
    rd_t r;
    forever begin
      @(negedge aclk); #1;
      if (bus.alu_en === 1'b1 && bus.alu_ready === 1'b1) begin
        if (alu_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL alu_unexpected: got instbus %h, required no pending entry", bus.alu_instbus);
        end else begin
          chk("alu_instbus", bus.alu_instbus, alu_q.pop_front());
        end
      end
      if (bus.ctrl_rd_wr === 1'b1) begin
        if (rd_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL rd_unexpected: got rd_wr=1 addr %h val %h, required rd_wr=0", bus.ctrl_rd_addr, bus.ctrl_rd_val);
        end else begin
          r = rd_q.pop_front();
          chk("rd_addr", {27'b0, bus.ctrl_rd_addr}, {27'b0, r.addr});
          chk("rd_val", bus.ctrl_rd_val, r.val);
        end
      end
    end
  end

  logic [31:0] dir_ins [23] = '{
    32'h00000017, 32'h00001017, 32'h00001197, 32'hFFFFFC17,
    32'h0000006F, 32'h000001EF, 32'h001002EF,
    32'h00000067, 32'h00100067, 32'h00200067,
    32'h00000863, 32'h00000863, 32'h00001863, 32'h00001863,
    32'h00004863, 32'h00004863, 32'h00005863, 32'h00005863, 32'h00005863,
    32'h00006863, 32'h00006863, 32'h00007863, 32'h00007863};
  logic [31:0] dir_a [23] = '{
    0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
    32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678,
    32'hFFFFFFFF, 32'h00FFFFFF, 32'h00FFFFFF, 32'h0FFFFFFF, 32'h0F0FFFFF,
    32'h0000FFFF, 32'h00FFFFFF, 32'h0FFFFFFF, 32'h00FFFFF0};
  logic [31:0] dir_b [23] = '{
    0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
    32'hFFFFFFFF, 32'h00000000, 32'h00FFFFFF, 32'h12345678,
    32'h00FFFFFF, 32'h00FFFFFF, 32'h00FFFFFF, 32'h00FFFFFF, 32'h0FFFFFFF,
    32'h00FFFFFF, 32'h00FFFFFF, 32'h00FFFFFF, 32'h00FFFFFF};
  logic [31:0] dir_pc [23] = '{
    32'h0000, 32'h1000, 32'h2000, 32'h1000,
    32'h0000, 32'h0000, 32'h0800,
    32'h0000, 32'h0000, 32'h0002,
    32'h10, 32'h14, 32'h24, 32'h28, 32'h38, 32'h3C, 32'h4C, 32'h5C, 32'h60,
    32'h70, 32'h74, 32'h84, 32'h88};

  initial begin
    logic [31:0] r, a, b, ins;
    bus.inst_rdata = 32'h0;
    bus.inst_ready = 1'b0;
    bus.ctrl_rs1_val = 32'h0;
    bus.ctrl_rs2_val = 32'h0;
    model_pc = 32'h0;

    do_reset();

    // Opcode validity decode, without handshaking.
    for (int i = 0; i < 11; i++) begin
      r = $urandom();
      bus.inst_rdata = {r[31:7], valid_opc[i]};
      #1 chk("inst_error_valid", {31'b0, dut.inst_error}, 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      r = $urandom();
      bus.inst_rdata = {r[31:7], bad_opc[i]};
      #1 chk("inst_error_bad", {31'b0, dut.inst_error}, 32'd1);
    end
    @(posedge aclk); #1;

    // ALU forwarding with a free ALU, then fill the FIFO with the ALU stalled.
    ready_mode = 1;
    for (int i = 0; i < 6; i++) begin
      r = $urandom();
      issue({r[31:7], alu_opc[i]}, r, ~r);
    end
    repeat (4) begin @(posedge aclk); #1; end
    ready_mode = 0;
    repeat (2) begin @(posedge aclk); #1; end
    for (int i = 0; i < 4; i++) begin
      r = $urandom();
      issue({r[31:7], 7'b1110011}, 32'h0, 32'h0);
    end
    r = $urandom();
    ins = {r[31:7], 7'b1110011};
    bus.inst_rdata = ins;
    bus.inst_ready = 1'b1;
    repeat (3) begin
      @(negedge aclk);
      chk("full_inst_en", {31'b0, bus.inst_en}, 32'd0);
      chk("full_alu_en", {31'b0, bus.alu_en}, 32'd1);
    end
    @(posedge aclk); #1;
    ready_mode = 1;
    issue(ins, 32'h0, 32'h0);
    repeat (8) begin @(posedge aclk); #1; end

    // Directed AUIPC / JAL / JALR / branch sequences.
    for (int i = 0; i < 23; i++) begin
      if (i == 0 || i == 4 || i == 7 || i == 10) do_reset();
      issue(dir_ins[i], dir_a[i], dir_b[i]);
      @(negedge aclk);
      chk("dir_pc", {16'b0, bus.inst_addr}, dir_pc[i]);
      @(posedge aclk); #1;
    end

    // Randomised mix with random ALU back-pressure and a mid-run reset.
    ready_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if (i == 150) do_reset();
      r = $urandom();
      case ($urandom_range(0, 12))
        11, 12:  ins = {r[31:7], bad_opc[$urandom_range(0, 2)]};
        default: ins = {r[31:7], valid_opc[$urandom_range(0, 10)]};
      endcase
      if (ins[6:0] == 7'b1100011) ins[14:12] = br_f3[$urandom_range(0, 5)];
      a = $urandom();
      b = ($urandom_range(0, 3) == 0) ? a : $urandom();
      issue(ins, a, b);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin @(posedge aclk); #1; end
      end
    end

    ready_mode = 1;
    repeat (10) begin @(posedge aclk); #1; end
    chk("alu_q_drained", alu_q.size(), 32'd0);
    chk("rd_q_drained", rd_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
